debouncer_multi: RTL
====================

// Module: debouncer_multi
// PURPOSE
//  - N-channel debouncer for switch, endstop and probe inputs, with a runtime threshold and per-channel edge events.
//  - Each channel: 2-flop synchroniser, optional inversion, and a stable-time counter.
//  - Outputs clean levels plus single-cycle rise/fall strobes and a sticky change flag to the register/host interface.
// PARAMETERS
//  - CHANNELS     8       number of independent input channels (1..32)
//  - CNT_W        16      stable-time counter width; max threshold 2^CNT_W-1 cycles
//  - INVERT_MASK  {CHANNELS{1'b1}}  per-channel bit; 1 = invert raw input (active-low pins)
//  - RESET_STATE  {CHANNELS{1'b0}}  per-channel debounced level after reset (post-inversion)
// PORTS
//  - clk        in   1           system clock; all logic on posedge
//  - rst_n      in   1           asynchronous active-low reset
//  - sig_in     in   CHANNELS    raw asynchronous pin levels
//  - thresh     in   CNT_W       debounce threshold, shared by all channels, sampled live every cycle
//  - chg_clr    in   CHANNELS    per-bit clear of the sticky change flag
//  - state      out  CHANNELS    debounced level
//  - rise       out  CHANNELS    1-cycle strobe, state went 0->1
//  - fall       out  CHANNELS    1-cycle strobe, state went 1->0
//  - changed    out  CHANNELS    sticky; set on any rise or fall
//  - glitch_cnt out  CHANNELS*8  rejected-bounce counters; present only with DEBOUNCE_GLITCH_CNT_EN
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - sync0/sync1/state = RESET_STATE; counters = 0
//    - rise = fall = changed = 0; glitch_cnt = 0
//    - No event is generated on reset release.
//  - Sync path: sync0 <= sig_in ^ INVERT_MASK; sync1 <= sync0.
//  - Per channel, every cycle:
//    - sync1 == state: cnt <= 0.
//    - Else, cnt >= thresh: state <= sync1; cnt <= 0; rise or fall <= 1 for exactly that cycle.
//    - Else: cnt <= cnt + 1. The counter never wraps, because the >= compare fires first.
//  - Latency: a level captured by sync0 at edge E reaches state at edge E+2+thresh.
//    - thresh = 0 gives a pure 2-flop-plus-1 pipeline.
//  - Glitch: sync1 returns to state while cnt != 0. The counter clears and state is unchanged.
//  - Threshold lowered mid-count below the current cnt: toggle on the next edge (>= compare).
//  - Threshold raised mid-count: counting continues to the new value.
//  - rise/fall are registered and coincide with the first cycle of the new state. They are never both high.
//  - changed:
//    - Set on the edge after a rise or fall cycle.
//    - chg_clr bit clears it on the next edge.
//    - If set and clear land on the same edge, set wins (no lost events).
//  - Channels are fully independent; simultaneous toggles on several channels are all reported in the same cycle.
// CONFIGURATION
//  - DEBOUNCE_GLITCH_CNT_EN defined:
//    - Per-channel 8-bit glitch_cnt increments on each glitch and saturates at 255.
//    - The counter clears when that channel's chg_clr bit is asserted.
//    - If clear and increment coincide, clear wins, then that glitch is counted (value 1).
//  - DEBOUNCE_GLITCH_CNT_EN undefined:
//    - The glitch_cnt port and its logic are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - Shared include debounce_pkg.vh:
//    - GLITCH_W = 8
//    - default CNT_W
//    - localparams for the reset-state encoding
//  - Sub-module debounce_chan: one channel (sync, counter, state, strobes, optional glitch counter).
//  - debouncer_multi instantiates it CHANNELS times in a generate loop. The sticky flag lives in debouncer_multi.
// TESTING
//  - T1 Reset: rst_n=0 with sig_in toggling, INVERT_MASK=1, RESET_STATE=0, then release.
//    - Required: state=0, no rise/fall/changed.
//    - Pins held high -> state stays 0.
//  - T2 Latency: thresh=4, ch0 pin falls (inverted -> 1) at edge E.
//    - Required: state[0]=1 and rise[0]=1 at E+6, rise low at E+7.
//    - changed[0]=1 from E+7.
//  - T3 Bounce: thresh=10, ch1 level pulses 5 cycles then returns.
//    - Required: state/rise unchanged.
//    - glitch_cnt[1]=1 (macro on); 3 such pulses -> 3.
//  - T4 Threshold drop: thresh=100, ch2 stable-new for 50 cycles, then thresh set to 20.
//    - Required: toggle on the next edge.
//  - T5 Parallel + sticky: all 8 channels toggle at the same edge with thresh=0.
//    - Required: all rise at E+2.
//    - chg_clr=8'hFF on the same edge changed sets -> changed stays 8'hFF; next clear -> 8'h00.
//  - T6 Mid-count reset: rst_n pulsed low at cnt=3 of thresh=8.
//    - Required: immediate return to reset values.
//    - Fresh full debounce needed afterwards.

Source files
------------

// File: rtl/debouncer_multi_pkg.sv
// Shared constants for debouncer_multi: glitch counter width, default
// stable-time counter width and the reset-level encodings.
package debouncer_multi_pkg;

  localparam int GLITCH_W  = 8;
  localparam int DEF_CNT_W = 16;

  localparam logic RST_LVL_LOW  = 1'b0;
  localparam logic RST_LVL_HIGH = 1'b1;

  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

endpackage

// File: rtl/debouncer_multi_chan.sv
// One debounce channel: 2-flop synchroniser, stable-time counter, level and strobes.
// Optional rejected-bounce counter when DEBOUNCE_GLITCH_CNT_EN is defined.
module debouncer_multi_chan
  import debouncer_multi_pkg::*;
#(
  parameter int   CNT_W     = DEF_CNT_W,
  parameter logic INVERT    = 1'b1,
  parameter logic RESET_VAL = RST_LVL_LOW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  input  logic [CNT_W-1:0]    thresh,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                chg_clr,
  output logic [GLITCH_W-1:0] glitch_cnt,
`endif
  output logic                state,
  output logic                rise,
  output logic                fall
);

  logic             sync0;
  logic             sync1;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             fire;

  assign differ = (sync1 != state);
  // Compare with >= so a threshold lowered below the running count fires at once.
  assign fire   = differ && (cnt >= thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= RESET_VAL;
      sync1 <= RESET_VAL;
      state <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync0 <= sig_in ^ INVERT;
      sync1 <= sync0;
      rise  <= fire && sync1;
      fall  <= fire && !sync1;
      if (!differ || fire) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fire) begin
        state <= sync1;
      end
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic glitch;

  // A bounce is a return to the held level after counting had started.
  assign glitch = !differ && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt <= '0;
    end else if (chg_clr) begin
      glitch_cnt <= glitch ? GLITCH_W'(1) : '0;
    end else if (glitch && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_W'(1);
    end
  end
`endif

endmodule

// File: rtl/debouncer_multi.sv
// N-channel debouncer with shared live threshold, edge strobes and sticky change flags.
// Define DEBOUNCE_GLITCH_CNT_EN to add the per-channel glitch_cnt output.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int                  CHANNELS    = 8,
  parameter int                  CNT_W       = DEF_CNT_W,
  parameter logic [CHANNELS-1:0] INVERT_MASK = {CHANNELS{1'b1}},
  parameter logic [CHANNELS-1:0] RESET_STATE = {CHANNELS{RST_LVL_LOW}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS-1:0]          sig_in,
  input  logic [CNT_W-1:0]             thresh,
  input  logic [CHANNELS-1:0]          chg_clr,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [CHANNELS*GLITCH_W-1:0] glitch_cnt,
`endif
  output logic [CHANNELS-1:0]          state,
  output logic [CHANNELS-1:0]          rise,
  output logic [CHANNELS-1:0]          fall,
  output logic [CHANNELS-1:0]          changed
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debouncer_multi_chan #(
      .CNT_W     (CNT_W),
      .INVERT    (INVERT_MASK[i]),
      .RESET_VAL (RESET_STATE[i])
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .sig_in     (sig_in[i]),
      .thresh     (thresh),
`ifdef DEBOUNCE_GLITCH_CNT_EN
      .chg_clr    (chg_clr[i]),
      .glitch_cnt (glitch_cnt[i*GLITCH_W +: GLITCH_W]),
`endif
      .state      (state[i]),
      .rise       (rise[i]),
      .fall       (fall[i])
    );
  end

  // New events win over a coinciding clear so no change is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= '0;
    end else begin
      changed <= (changed & ~chg_clr) | rise | fall;
    end
  end

endmodule
